// File: rtl/apb_pkg.sv
// apb_pkg
//   Shared APB3 definitions for the completer register file:
//   bus widths, completer FSM state encoding and pslverr response codes.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // pslverr response encoding
  localparam logic OKAY  = 1'b0;
  localparam logic ERROR = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_completer_regfile.sv
// apb_completer_regfile
//   APB3 completer holding DEPTH word registers. Each transfer is a setup
//   cycle followed by WAIT_CYCLES pready-low cycles and one completion cycle.
//   Misaligned or out-of-window accesses complete with pslverr and never
//   touch the register file.
//
// Ports
//   hclk     clock, rising edge
//   hreset   synchronous reset, active-high
//   psel     completer select
//   penable  access phase
//   pwrite   1=write, 0=read
//   paddr    byte address
//   pwdata   write data
//   prdata   read data, valid with pready on a read
//   pready   transfer completes this cycle
//   pslverr  error response, valid with pready
import apb_pkg::*;

module apb_completer_regfile #(
  parameter int                    DEPTH       = 16,
  parameter int                    WAIT_CYCLES = 1,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int                    IDX_W = $clog2(DEPTH);
  localparam logic [APB_ADDR_W-1:0] SPAN  = APB_ADDR_W'(DEPTH * 4);

  apb_state_e state, state_nxt;

  logic [3:0]            cnt;
  logic                  wr_l;
  logic                  err_l;
  logic [APB_DATA_W-1:0] wdata_l;
  logic [IDX_W-1:0]      idx_l;
  logic [APB_DATA_W-1:0] mem [DEPTH];

  // Address decode; the subtraction wraps so addresses below BASE_ADDR
  // land far above the window and are flagged as errors.
  logic [APB_ADDR_W-1:0] off;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;

  assign off     = paddr - BASE_ADDR;
  assign dec_err = (paddr[1:0] != 2'b00) || (off >= SPAN);
  assign dec_idx = off[2 +: IDX_W];

  logic setup, complete;

  // penable without a preceding setup is not a setup; IDLE ignores it.
  assign setup    = (state == IDLE) && psel && !penable;
  assign pready   = (state == ACCESS) && (cnt == 4'd0);
  assign complete = (state == ACCESS) && psel && penable && pready;
  assign pslverr  = pready ? err_l : OKAY;

  always_ff @(posedge hclk) begin
    if (hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (setup) state_nxt = ACCESS;
      // Dropping psel mid-transfer abandons it silently.
      ACCESS:  if (!psel || complete) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      cnt     <= 4'd0;
      wr_l    <= 1'b0;
      err_l   <= OKAY;
      wdata_l <= '0;
      idx_l   <= '0;
      prdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (setup) begin
        wr_l    <= pwrite;
        err_l   <= dec_err ? ERROR : OKAY;
        wdata_l <= pwdata;
        idx_l   <= dec_idx;
        cnt     <= 4'(WAIT_CYCLES);
        // Read data is captured at setup so it is stable through the waits.
        prdata  <= dec_err ? '0 : mem[dec_idx];
      end else if ((state == ACCESS) && psel && penable && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // Commit on completion so a back-to-back read sees the new value.
      if (complete && wr_l && !err_l) mem[idx_l] <= wdata_l;
    end
  end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// tb_apb_completer_regfile
//   Two completers (WAIT_CYCLES=1 and 0) share one APB master; psel is
//   steered to one of them. The driver pushes expected responses from an
//   array model; a monitor pops and compares on every completion.
module tb_apb_completer_regfile;

  logic        hclk, hreset;
  logic        psel, penable, pwrite, use0;
  logic [31:0] paddr, pwdata;
  logic        psel0, psel1;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [31:0] rd_m;
  logic        rdy_m, err_m;

  assign psel1 = psel & ~use0;
  assign psel0 = psel & use0;
  assign rd_m  = use0 ? prdata0  : prdata1;
  assign rdy_m = use0 ? pready0  : pready1;
  assign err_m = use0 ? pslverr0 : pslverr1;

  apb_completer_regfile #(.DEPTH(16), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u1 (
    .hclk(hclk), .hreset(hreset), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata1), .pready(pready1), .pslverr(pslverr1));

  apb_completer_regfile #(.DEPTH(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u0 (
    .hclk(hclk), .hreset(hreset), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0));

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: 16-word window at byte 0, word-aligned only.
  task automatic push_exp(input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   err;
    int   idx;
    err  = (a % 4 != 0) || (a >= 64);
    idx  = err ? 0 : int'(a / 4);
    e.rd  = !wr;
    e.err = err;
    e.data = err ? 32'h0 : (use0 ? mem0[idx] : mem1[idx]);
    q.push_back(e);
    if (wr && !err) begin
      if (use0) mem0[idx] = d;
      else      mem1[idx] = d;
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
    end
  endtask

  // Entered and left at posedge+1, so consecutive calls are back-to-back.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, output int cyc);
    bit ok;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    push_exp(wr, a, d);
    @(negedge hclk);
    chk("pready_setup", {31'b0, rdy_m}, 32'h0);
    @(posedge hclk); #1;
    penable = 1'b1;
    cyc = 2;
    ok  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      if (rdy_m) begin ok = 1'b1; break; end
      @(posedge hclk); #1;
      cyc++;
    end
    if (!ok) chk("timeout", 32'h0, 32'h1);
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("latency", cyc, use0 ? 32'd2 : 32'd3);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  // Scoreboard monitor
  always @(negedge hclk) begin
    exp_t e;
    if (!hreset && psel && penable && rdy_m) begin
      if (q.size() == 0) chk("sb_empty", 32'h1, 32'h0);
      else begin
        e = q.pop_front();
        chk("pslverr", {31'b0, err_m}, {31'b0, e.err});
        if (e.rd) chk("prdata", rd_m, e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int c, tot;
    logic [31:0] a, d;
    hreset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; use0 = 1'b0;
    clear_model();
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_prdata1", prdata1, 32'h0);
    chk("rst_pready1", {31'b0, pready1}, 32'h0);
    chk("rst_pslverr1", {31'b0, pslverr1}, 32'h0);
    chk("rst_prdata0", prdata0, 32'h0);
    chk("rst_pready0", {31'b0, pready0}, 32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    idle(1);

    // Write then read back-to-back, one wait state
    xfer(1, 32'h4, 32'hDEAD_BEEF, c);
    xfer(0, 32'h4, 32'h0, c);
    idle(1);
    // Out-of-range write, no aliasing onto register 0
    xfer(1, 32'h40, 32'h1234, c);
    xfer(0, 32'h0, 32'h0, c);
    xfer(0, 32'h40, 32'h0, c);
    // Misaligned read then back-to-back write/read
    xfer(0, 32'h6, 32'h0, c);
    xfer(1, 32'h8, 32'hA5A5_A5A5, c);
    xfer(0, 32'h8, 32'h0, c);
    idle(2);

    // Zero-wait instance: four back-to-back writes in 8 cycles
    use0 = 1'b1;
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      xfer(1, 32'(i * 4), 32'(i + 1), c);
      tot += c;
    end
    chk("b2b_total_cycles", tot, 32'd8);
    for (int i = 0; i < 4; i++) xfer(0, 32'(i * 4), 32'h0, c);
    idle(1);

    // Reset during the wait cycle of a write
    use0 = 1'b0;
    xfer(1, 32'hC, 32'h1111_2222, c);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFF_FFFF;
    @(posedge hclk); #1;
    penable = 1'b1; hreset = 1'b1;
    @(posedge hclk); #1;
    hreset = 1'b0; psel = 1'b0; penable = 1'b0;
    clear_model();
    @(negedge hclk);
    chk("rstmid_pready", {31'b0, pready1}, 32'h0);
    chk("rstmid_pslverr", {31'b0, pslverr1}, 32'h0);
    chk("rstmid_prdata", prdata1, 32'h0);
    idle(1);
    xfer(0, 32'hC, 32'h0, c);
    idle(1);

    // Abort: psel dropped in the wait cycle
    xfer(1, 32'h4, 32'h77, c);
    idle(1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h55;
    @(posedge hclk); #1;
    psel = 1'b0;
    idle(2);
    xfer(0, 32'h4, 32'h0, c);
    xfer(1, 32'h8, 32'h1357_9BDF, c);
    xfer(0, 32'h8, 32'h0, c);

    // Randomized mix across both instances
    for (int n = 0; n < 80; n++) begin
      use0 = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
        1:       a = 32'h40 + 32'($urandom_range(0, 63) * 4);
        2:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
        default: a = 32'($urandom_range(0, 15) * 4);
      endcase
      d = $urandom;
      xfer(1'($urandom_range(0, 1)), a, d, c);
      idle($urandom_range(0, 2));
    end

    idle(3);
    chk("sb_drained", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_completer_regfile.md
Name: apb_completer_regfile

Overview:
APB3 completer (slave) that terminates transfers issued by the team's AHB-to-APB bridge. It holds a word-addressed register file and inserts a configurable number of wait states via pready. It flags out-of-range or misaligned accesses on pslverr. It sits on the APB side of the bridge as the standard peripheral model and real register block.

Parameters:
DEPTH, 16, number of 32-bit registers (power of 2, 2..256)
WAIT_CYCLES, 1, pready-low cycles in each access phase (0..15)
BASE_ADDR, 32'h0000_0000, byte address of register 0 (DEPTH*4 aligned)

Ports:
hclk  input  1  clock, all logic on rising edge
hreset  input  1  synchronous reset, active-high
psel  input  1  completer select
penable  input  1  access phase
pwrite  input  1  1=write, 0=read
paddr  input  32  byte address
pwdata  input  32  write data
prdata  output  32  read data, valid when pready=1 on a read
pready  output  1  transfer completes this cycle
pslverr  output  1  error response, valid only with pready=1

Behaviour:
- Clock/reset (already decided): one clock, hclk; reset hreset is synchronous and active-high.
- Reset: state=IDLE, prdata=0, pready=0, pslverr=0, wait counter=0, all registers=0. Reset overrides everything, including mid-transfer; no write commits on a reset edge.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel=1 and penable=0 (setup phase), latch pwrite, pwdata, the word index and the error flag.
  - Load counter with WAIT_CYCLES and go to ACCESS.
  - penable=1 without a prior setup is ignored; stay in IDLE.
- Address decode:
  - off = paddr - BASE_ADDR (32-bit, wraps).
  - err = (paddr[1:0] != 0) or (off >= DEPTH*4).
  - index = off[2 +: clog2(DEPTH)].
- Read data: on the setup edge, prdata loads mem[index], or 0 if err. prdata holds its value otherwise.
- ACCESS:
  - pready = (cnt == 0), combinational from state and counter.
  - If cnt != 0 and psel & penable: cnt decrements each cycle.
  - Completion edge (psel & penable & pready):
    - a write with no error updates mem[index] with the latched pwdata;
    - go to IDLE.
  - pslverr = pready & err_latched. An errored write does not modify any register.
  - Abort: psel=0 while in ACCESS returns to IDLE with no write and no response (protocol violation tolerated).
- Latency: WAIT_CYCLES=N gives a transfer of 2+N cycles (setup, N wait, 1 completion). N=0 gives the 2-cycle minimum.
- Back-to-back: the master's next setup arrives the cycle after completion. IDLE accepts it immediately, with no dead cycle.
- pready is 0 in IDLE.
- Read-after-write to the same address on consecutive transfers returns the new data, because the write commits before the next setup edge.
- paddr, pwrite and pwdata changes during ACCESS are ignored; the latched values are used.

Decomposition:
- Package apb_pkg holds:
  - the state enum (IDLE, ACCESS);
  - APB_ADDR_W=32 and APB_DATA_W=32;
  - the pslverr encoding constants OKAY=0 and ERROR=1.
- No sub-module: decode, counter and storage are all in a single module, about 150 lines.

Test Plan:
- Write 0x0000_0004 <- 0xDEAD_BEEF, WAIT_CYCLES=1:
  - setup at t0, pready=0 at t1, pready=1 with pslverr=0 at t2;
  - then read 0x4 -> prdata=0xDEAD_BEEF, pslverr=0, completes at t5.
- Out-of-range write 0x40 <- 0x1234 (DEPTH=16):
  - pslverr=1 with pready;
  - a following read of 0x0 returns 0 (no aliasing);
  - a read of 0x40 returns prdata=0 with pslverr=1.
- Misaligned read 0x6 -> pslverr=1, prdata=0.
  - Then write 0x8 <- 0xA5A5_A5A5 back-to-back with no idle cycle -> OK.
  - Read 0x8 -> 0xA5A5_A5A5.
- WAIT_CYCLES=0 instance: 4 back-to-back writes to 0x0..0xC with data 1..4:
  - each completes in 2 cycles, 8 cycles total;
  - readback returns 1,2,3,4.
- hreset asserted during the wait cycle of a write 0xC <- 0xFFFF_FFFF:
  - next cycle pready=0, pslverr=0, prdata=0;
  - a later read of 0xC returns 0.
- Abort: psel dropped during the wait cycle of a write 0x4 <- 0x55:
  - FSM returns to IDLE;
  - register 1 is unchanged;
  - the next transfer completes normally.
